// File: rtl/cms_pix28_cmd_issuer.sv
// Host-side command issuer for the firmware command word {device_id, op_code, body}, with EXECUTE status polling.
// Optional macro CMS_PIX28_CMD_AUTO_CLEAR_EN: issue a status-clear command before every W_EXECUTE.
module cms_pix28_cmd_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TEST_NUM_LSB   = 12
) (
    input  logic        fw_axi_clk,
    input  logic        fw_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_device_id,
    input  logic [3:0]  cmd_op_code,
    input  logic [23:0] cmd_body,
    output logic [31:0] wr_word,
    output logic        wr_strobe,
    input  logic [31:0] status_word,
    output logic        rsp_valid,
    output logic [1:0]  rsp_code,
    output logic        busy
);

    localparam logic [3:0]  OP_CODE_W_EXECUTE = 4'hF;
`ifdef CMS_PIX28_CMD_AUTO_CLEAR_EN
    localparam logic [3:0]  OP_CODE_W_STATUS_FW_CLEAR = 4'hE;
`endif
    localparam logic [1:0]  RSP_OK       = 2'b00;
    localparam logic [1:0]  RSP_TIMEOUT  = 2'b01;
    localparam logic [1:0]  RSP_FW_ERROR = 2'b10;
    localparam logic [1:0]  RSP_BAD_CFG  = 2'b11;
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  GAP_LAST     = 4'(GAP_CYCLES - 1);

`ifdef CMS_PIX28_CMD_AUTO_CLEAR_EN
    typedef enum logic [2:0] {IDLE, CHECK, CLEAR, CLEAR_GAP, ISSUE, GAP, POLL, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, GAP, POLL, RESP} state_t;
`endif

    state_t      state;
    state_t      next_state;
    logic [3:0]  dev_q;
    logic [3:0]  op_q;
    logic [23:0] body_q;
    logic [3:0]  gap_cnt;
    logic [23:0] tmo_cnt;
    logic [1:0]  rsp_code_next;
    logic [31:0] word_next;
    logic        strobe_next;
    logic        gap_run;
    logic        is_exec;
    logic [3:0]  test_field;
    logic        test_done;
    logic        unused_status;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign is_exec    = (op_q == OP_CODE_W_EXECUTE);
    assign test_field = body_q[TEST_NUM_LSB +: 4];
    // test_field is known one-hot in POLL, so this selects status bit 14 + log2(test_number)
    assign test_done  = |(status_word[17:14] & test_field);
    assign unused_status = ^{status_word[30:18], status_word[13:0]};

    always_comb begin
        next_state    = state;
        rsp_code_next = rsp_code;
        word_next     = wr_word;
        strobe_next   = 1'b0;
        gap_run       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) next_state = CHECK;
            end
            CHECK: begin
                if (!is_one_hot(dev_q) || (is_exec && !is_one_hot(test_field))) begin
                    next_state    = RESP;
                    rsp_code_next = RSP_BAD_CFG;
                end else begin
`ifdef CMS_PIX28_CMD_AUTO_CLEAR_EN
                    next_state = is_exec ? CLEAR : ISSUE;
`else
                    next_state = ISSUE;
`endif
                end
            end
`ifdef CMS_PIX28_CMD_AUTO_CLEAR_EN
            CLEAR: begin
                next_state = CLEAR_GAP;
            end
            CLEAR_GAP: begin
                gap_run = 1'b1;
                if (gap_cnt == GAP_LAST) next_state = ISSUE;
            end
`endif
            ISSUE: begin
                next_state = GAP;
            end
            GAP: begin
                gap_run = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    if (is_exec) begin
                        next_state = POLL;
                    end else begin
                        next_state    = RESP;
                        rsp_code_next = RSP_OK;
                    end
                end
            end
            POLL: begin
                // Firmware error outranks a simultaneous done bit
                if (status_word[31]) begin
                    next_state    = RESP;
                    rsp_code_next = RSP_FW_ERROR;
                end else if (test_done) begin
                    next_state    = RESP;
                    rsp_code_next = RSP_OK;
                end else if (tmo_cnt == TIMEOUT_LAST) begin
                    next_state    = RESP;
                    rsp_code_next = RSP_TIMEOUT;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (next_state == ISSUE) begin
            strobe_next = 1'b1;
            word_next   = {dev_q, op_q, body_q};
        end
`ifdef CMS_PIX28_CMD_AUTO_CLEAR_EN
        if (next_state == CLEAR) begin
            strobe_next = 1'b1;
            word_next   = {dev_q, OP_CODE_W_STATUS_FW_CLEAR, 24'h0};
        end
`endif
    end

    always_ff @(posedge fw_axi_clk) begin
        if (!fw_rst_n) begin
            state     <= IDLE;
            dev_q     <= '0;
            op_q      <= '0;
            body_q    <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            wr_word   <= '0;
            wr_strobe <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_code  <= RSP_OK;
        end else begin
            state     <= next_state;
            wr_word   <= word_next;
            wr_strobe <= strobe_next;
            rsp_valid <= (next_state == RESP);
            if (next_state == RESP) rsp_code <= rsp_code_next;
            if (state == IDLE && cmd_valid) begin
                dev_q  <= cmd_device_id;
                op_q   <= cmd_op_code;
                body_q <= cmd_body;
            end
            gap_cnt <= (gap_run && next_state == state) ? gap_cnt + 4'd1 : 4'd0;
            // Poll counter saturates instead of wrapping
            if (state == POLL && next_state == POLL) begin
                if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 24'd1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cms_pix28_cmd_issuer.sv
// Directed self-checking bench for cms_pix28_cmd_issuer (GAP_CYCLES=4, TIMEOUT_CYCLES=100, TEST_NUM_LSB=12).
// Follows CMS_PIX28_CMD_AUTO_CLEAR_EN if it is defined for the build.
module tb_cms_pix28_cmd_issuer;

    localparam int GAP = 4;
    localparam int TMO = 100;
`ifdef CMS_PIX28_CMD_AUTO_CLEAR_EN
    localparam int EXTRA        = GAP + 1;
    localparam int EXEC_STROBES = 2;
`else
    localparam int EXTRA        = 0;
    localparam int EXEC_STROBES = 1;
`endif

    logic        fw_axi_clk = 1'b0;
    logic        fw_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_device_id;
    logic [3:0]  cmd_op_code;
    logic [23:0] cmd_body;
    logic [31:0] wr_word;
    logic        wr_strobe;
    logic [31:0] status_word;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    logic [31:0] strobe_log [0:7];

    cms_pix28_cmd_issuer #(
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES(GAP),
        .TEST_NUM_LSB(12)
    ) dut (
        .fw_axi_clk(fw_axi_clk),
        .fw_rst_n(fw_rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_device_id(cmd_device_id),
        .cmd_op_code(cmd_op_code),
        .cmd_body(cmd_body),
        .wr_word(wr_word),
        .wr_strobe(wr_strobe),
        .status_word(status_word),
        .rsp_valid(rsp_valid),
        .rsp_code(rsp_code),
        .busy(busy)
    );

    always #5 fw_axi_clk = ~fw_axi_clk;

    // Strobe monitor: each high cycle counts as one strobe, words logged in order
    always @(negedge fw_axi_clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_log[strobe_cnt[2:0]] <= wr_word;
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge fw_axi_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [3:0] dev, input logic [3:0] op, input logic [23:0] body);
        cmd_valid     = 1'b1;
        cmd_device_id = dev;
        cmd_op_code   = op;
        cmd_body      = body;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max_cycles, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max_cycles && cycles < 0; i++) begin
            tick;
            if (rsp_valid === 1'b1) cycles = i;
        end
    endtask

    task automatic test_reset;
        fw_rst_n = 1'b0;
        tick;
        tick;
        checks++; if (wr_word !== 32'h0) begin errors++; $display("[TB] FAIL reset_wr_word: got %h expected %h", wr_word, 32'h0); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_code !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_code: got %b expected 00", rsp_code); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        fw_rst_n = 1'b1;
        tick;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_cfg_write;
        int s0;
        int c;
        s0 = strobe_cnt;
        send_cmd(4'h2, 4'h2, 24'h0A0B0C);
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL cfg_busy: got busy=%b ready=%b expected 1/0", busy, cmd_ready); end
        wait_rsp(20, c);
        checks++; if (c != GAP + 2) begin errors++; $display("[TB] FAIL cfg_latency: got %0d expected %0d", c, GAP + 2); end
        checks++; if (rsp_code !== 2'b00) begin errors++; $display("[TB] FAIL cfg_rsp_code: got %b expected 00", rsp_code); end
        checks++; if (wr_word !== 32'h220A0B0C) begin errors++; $display("[TB] FAIL cfg_wr_word: got %h expected 220a0b0c", wr_word); end
        checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("[TB] FAIL cfg_strobes: got %0d expected 1", strobe_cnt - s0); end
        tick;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL cfg_after_rsp: got valid=%b ready=%b expected 0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_execute_done;
        int s0;
        int c;
        logic seen;
        s0 = strobe_cnt;
        seen = 1'b0;
        status_word = 32'h0;
        send_cmd(4'h1, 4'hF, 24'h001000);
        for (int i = 0; i < 2 + GAP + 49 + EXTRA; i++) begin
            tick;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL exec_early_rsp: got %b expected 0", seen); end
        status_word = 32'h0000_4000;
        wait_rsp(5, c);
        status_word = 32'h0;
        checks++; if (c != 1) begin errors++; $display("[TB] FAIL exec_done_latency: got %0d expected 1", c); end
        checks++; if (rsp_code !== 2'b00) begin errors++; $display("[TB] FAIL exec_rsp_code: got %b expected 00", rsp_code); end
        checks++; if (strobe_cnt - s0 != EXEC_STROBES) begin errors++; $display("[TB] FAIL exec_strobes: got %0d expected %0d", strobe_cnt - s0, EXEC_STROBES); end
        checks++; if (wr_word !== 32'h1F001000) begin errors++; $display("[TB] FAIL exec_wr_word: got %h expected 1f001000", wr_word); end
`ifdef CMS_PIX28_CMD_AUTO_CLEAR_EN
        checks++; if (strobe_log[s0[2:0]] !== 32'h1E000000) begin errors++; $display("[TB] FAIL exec_clear_word: got %h expected 1e000000", strobe_log[s0[2:0]]); end
`endif
        tick;
    endtask

    task automatic test_bad_cfg;
        int s0;
        int c;
        logic [31:0] w0;
        s0 = strobe_cnt;
        w0 = wr_word;
        send_cmd(4'h1, 4'hF, 24'h003000);
        wait_rsp(10, c);
        checks++; if (c != 1) begin errors++; $display("[TB] FAIL bad_test_latency: got %0d expected 1", c); end
        checks++; if (rsp_code !== 2'b11) begin errors++; $display("[TB] FAIL bad_test_code: got %b expected 11", rsp_code); end
        tick;
        send_cmd(4'h3, 4'hF, 24'h001000);
        wait_rsp(10, c);
        checks++; if (c != 1) begin errors++; $display("[TB] FAIL bad_dev_latency: got %0d expected 1", c); end
        checks++; if (rsp_code !== 2'b11) begin errors++; $display("[TB] FAIL bad_dev_code: got %b expected 11", rsp_code); end
        for (int i = 0; i < 10; i++) tick;
        checks++; if (strobe_cnt - s0 != 0) begin errors++; $display("[TB] FAIL bad_strobes: got %0d expected 0", strobe_cnt - s0); end
        checks++; if (wr_word !== w0) begin errors++; $display("[TB] FAIL bad_wr_word: got %h expected %h", wr_word, w0); end
    endtask

    task automatic test_timeout;
        int c;
        status_word = 32'h0000_4000;
        send_cmd(4'h4, 4'hF, 24'h004000);
        wait_rsp(300, c);
        status_word = 32'h0;
        checks++; if (c != 2 + GAP + TMO + EXTRA) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", c, 2 + GAP + TMO + EXTRA); end
        checks++; if (rsp_code !== 2'b01) begin errors++; $display("[TB] FAIL timeout_code: got %b expected 01", rsp_code); end
        checks++; if (wr_word !== 32'h4F004000) begin errors++; $display("[TB] FAIL timeout_wr_word: got %h expected 4f004000", wr_word); end
        tick;
    endtask

    task automatic test_fw_error;
        int c;
        status_word = 32'h8000_8000;
        send_cmd(4'h8, 4'hF, 24'h002000);
        wait_rsp(50, c);
        checks++; if (c != 3 + GAP + EXTRA) begin errors++; $display("[TB] FAIL fwerr_latency: got %0d expected %0d", c, 3 + GAP + EXTRA); end
        checks++; if (rsp_code !== 2'b10) begin errors++; $display("[TB] FAIL fwerr_code: got %b expected 10", rsp_code); end
        tick;
        status_word = 32'h0000_8000;
        send_cmd(4'h8, 4'hF, 24'h002000);
        wait_rsp(50, c);
        status_word = 32'h0;
        checks++; if (c != 3 + GAP + EXTRA) begin errors++; $display("[TB] FAIL test2_done_latency: got %0d expected %0d", c, 3 + GAP + EXTRA); end
        checks++; if (rsp_code !== 2'b00) begin errors++; $display("[TB] FAIL test2_done_code: got %b expected 00", rsp_code); end
        tick;
    endtask

    task automatic test_busy_ignore;
        int s0;
        int c;
        s0 = strobe_cnt;
        send_cmd(4'h2, 4'h0, 24'h123456);
        cmd_valid     = 1'b1;
        cmd_device_id = 4'h4;
        cmd_op_code   = 4'h2;
        cmd_body      = 24'hABCDEF;
        tick;
        tick;
        tick;
        cmd_valid = 1'b0;
        wait_rsp(20, c);
        checks++; if (c != GAP - 1) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected %0d", c, GAP - 1); end
        checks++; if (wr_word !== 32'h20123456) begin errors++; $display("[TB] FAIL busy_wr_word: got %h expected 20123456", wr_word); end
        checks++; if (strobe_cnt - s0 != 1) begin errors++; $display("[TB] FAIL busy_strobes: got %0d expected 1", strobe_cnt - s0); end
        tick;
    endtask

    task automatic test_reset_in_poll;
        int s0;
        int c;
        logic seen;
        seen = 1'b0;
        status_word = 32'h0;
        send_cmd(4'h1, 4'hF, 24'h001000);
        for (int i = 0; i < 2 + GAP + 10 + EXTRA; i++) tick;
        fw_rst_n = 1'b0;
        tick;
        fw_rst_n = 1'b1;
        s0 = strobe_cnt;
        checks++; if (wr_word !== 32'h0 || wr_strobe !== 1'b0) begin errors++; $display("[TB] FAIL rst_poll_wr: got %h/%b expected 00000000/0", wr_word, wr_strobe); end
        checks++; if (rsp_valid !== 1'b0 || rsp_code !== 2'b00) begin errors++; $display("[TB] FAIL rst_poll_rsp: got %b/%b expected 0/00", rsp_valid, rsp_code); end
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_poll_idle: got busy=%b ready=%b expected 0/1", busy, cmd_ready); end
        for (int i = 0; i < 150; i++) begin
            tick;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0 || strobe_cnt != s0) begin errors++; $display("[TB] FAIL rst_poll_aborted: got rsp=%b strobes=%0d expected 0/0", seen, strobe_cnt - s0); end
        send_cmd(4'h2, 4'h2, 24'h0A0B0C);
        wait_rsp(20, c);
        checks++; if (c != GAP + 2 || rsp_code !== 2'b00) begin errors++; $display("[TB] FAIL rst_poll_next_cmd: got %0d/%b expected %0d/00", c, rsp_code, GAP + 2); end
        checks++; if (wr_word !== 32'h220A0B0C) begin errors++; $display("[TB] FAIL rst_poll_next_word: got %h expected 220a0b0c", wr_word); end
        tick;
    endtask

    initial begin
        fw_rst_n      = 1'b0;
        cmd_valid     = 1'b0;
        cmd_device_id = 4'h0;
        cmd_op_code   = 4'h0;
        cmd_body      = 24'h0;
        status_word   = 32'h0;
        test_reset;
        test_cfg_write;
        test_execute_done;
        test_bad_cfg;
        test_timeout;
        test_fw_error;
        test_busy_ignore;
        test_reset_in_poll;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
